// File: rtl/m62_rom_loader_if.sv
// m62_rom_loader_if: ioctl download stream, SDRAM toggle ports, sound/PROM strobes and load status.
// rom_sum exists only when LOADER_CHECKSUM_EN is defined.
interface m62_rom_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        port1_req, port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req, port2_ack;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        snd_wr;
    logic [15:0] snd_addr;
    logic [7:0]  snd_data;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        port_we;
    logic        rom_loaded;
    logic        core_reset;
    logic        user_reset;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] rom_sum;
`endif

    modport master (
`ifdef LOADER_CHECKSUM_EN
        output rom_sum,
`endif
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, port1_ack, port2_ack, user_reset,
        output ioctl_wait, port1_req, port1_a, port1_ds, port1_d, port2_req, port2_a, port2_ds, port2_d,
        output snd_wr, snd_addr, snd_data, dl_wr, dl_addr, dl_data, port_we, rom_loaded, core_reset
    );

    modport slave (
`ifdef LOADER_CHECKSUM_EN
        input  rom_sum,
`endif
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, port1_ack, port2_ack, user_reset,
        input  ioctl_wait, port1_req, port1_a, port1_ds, port1_d, port2_req, port2_a, port2_ds, port2_d,
        input  snd_wr, snd_addr, snd_data, dl_wr, dl_addr, dl_data, port_we, rom_loaded, core_reset
    );
endinterface

// File: rtl/m62_rom_loader.sv
// m62_rom_loader: buffers ioctl ROM bytes and fans them out to SDRAM ports, sound dpram and PROM bus.
// Optional LOADER_CHECKSUM_EN adds rom_sum, the 16-bit sum of all issued bytes.
module m62_rom_loader #(
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] RST_STRETCH     = 16'hFFFF,
    parameter logic [19:0] GFX_BASE        = 20'h30000,
    parameter logic [19:0] SND_BASE        = 20'h20000,
    parameter logic [19:0] PROM_BASE       = 20'hA0000
) (
    input logic              clk_sys,
    input logic              reset_n,
    m62_rom_loader_if.master bus
);
    localparam int AW = FIFO_DEPTH_LOG2;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(2**AW);
    localparam logic [AW:0] HIGH_C  = (AW+1)'(2**AW - 2);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;
    state_t state_q, state_d;

    logic [32:0]   mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [24:0]   head_addr;
    logic [7:0]    head_data, data_q;
    logic [22:0]   p1_a_q, p2_a_q;
    logic [1:0]    ds_q;
    logic [15:0]   snd_addr_q, dl_addr_q, cnt_q, cnt_d;
    logic dl_active, dl_q, push_req, push, pop, empty, full, fall, done, loaded_set;
    logic drain_q, drain_d, gfx_q, snd_q, prom_q, p1_req_q, p2_req_q, snd_wr_q, dl_wr_q;
    logic wait_q, rom_loaded_q, core_reset_q;

    assign dl_active = bus.ioctl_download & (bus.ioctl_index == 8'd0);
    assign push_req  = bus.ioctl_wr & dl_active;
    assign empty     = count_q == '0;
    assign full      = count_q == DEPTH_C;
    assign push      = push_req & ~full;
    assign fall      = dl_q & ~dl_active;
    assign {head_addr, head_data} = mem_q[rd_ptr_q];
    assign done      = (bus.port1_ack == p1_req_q) & (~gfx_q | (bus.port2_ack == p2_req_q));
    assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign drain_d   = (drain_q | fall) & ~loaded_set;
    assign cnt_d     = (bus.user_reset | ~rom_loaded_q) ? RST_STRETCH : cnt_q - 16'(cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        loaded_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall & empty) loaded_set = 1'b1;
                else if (fall) state_d = S_DRAIN;
                else if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (done) state_d = (drain_q | fall) ? S_DRAIN : S_IDLE;
            default: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    loaded_set = 1'b1;
                    state_d    = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q] <= {bus.ioctl_addr, bus.ioctl_dout};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dl_q         <= 1'b0;
            drain_q      <= 1'b0;
            p1_a_q       <= '0;
            p2_a_q       <= '0;
            ds_q         <= '0;
            data_q       <= '0;
            snd_addr_q   <= '0;
            dl_addr_q    <= '0;
            gfx_q        <= 1'b0;
            snd_q        <= 1'b0;
            prom_q       <= 1'b0;
            p1_req_q     <= 1'b0;
            p2_req_q     <= 1'b0;
            snd_wr_q     <= 1'b0;
            dl_wr_q      <= 1'b0;
            wait_q       <= 1'b0;
            rom_loaded_q <= 1'b0;
            cnt_q        <= RST_STRETCH;
            core_reset_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            dl_q     <= dl_active;
            drain_q  <= drain_d;
            if (pop) begin
                p1_a_q     <= head_addr[23:1];
                ds_q       <= {head_addr[0], ~head_addr[0]};
                data_q     <= head_data;
                snd_addr_q <= head_addr[15:0];
                dl_addr_q  <= 16'(head_addr - 25'(PROM_BASE));
                gfx_q      <= head_addr >= 25'(GFX_BASE);
                snd_q      <= (head_addr >= 25'(SND_BASE)) & (head_addr < 25'(GFX_BASE));
                prom_q     <= head_addr >= 25'(PROM_BASE);
                if (head_addr >= 25'(GFX_BASE)) p2_a_q <= 23'((head_addr - 25'(GFX_BASE)) >> 1);
            end
            p1_req_q     <= p1_req_q ^ (state_q == S_ISSUE);
            p2_req_q     <= p2_req_q ^ ((state_q == S_ISSUE) & gfx_q);
            snd_wr_q     <= (state_q == S_ISSUE) & snd_q;
            dl_wr_q      <= (state_q == S_ISSUE) & prom_q;
            wait_q       <= (count_d >= HIGH_C) | (state_d == S_DRAIN);
            rom_loaded_q <= rom_loaded_q | loaded_set;
            cnt_q        <= cnt_d;
            core_reset_q <= cnt_d != '0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum_q;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else if (dl_active & ~dl_q) sum_q <= '0;
        else if ((state_q == S_ISSUE) & ~rom_loaded_q) sum_q <= sum_q + 16'(data_q);
    end
    assign bus.rom_sum = sum_q;
`endif

`ifndef SYNTHESIS
    // A byte arriving while the FIFO is full is dropped; the HPS ignored ioctl_wait.
    overflow_a: assert property (@(posedge clk_sys) disable iff (!reset_n) !(push_req & full));
`endif

    assign bus.ioctl_wait = wait_q;
    assign bus.port1_req  = p1_req_q;
    assign bus.port1_a    = p1_a_q;
    assign bus.port1_ds   = ds_q;
    assign bus.port1_d    = {data_q, data_q};
    assign bus.port2_req  = p2_req_q;
    assign bus.port2_a    = p2_a_q;
    assign bus.port2_ds   = ds_q;
    assign bus.port2_d    = {data_q, data_q};
    assign bus.snd_wr     = snd_wr_q;
    assign bus.snd_addr   = snd_addr_q;
    assign bus.snd_data   = data_q;
    assign bus.dl_wr      = dl_wr_q;
    assign bus.dl_addr    = dl_addr_q;
    assign bus.dl_data    = data_q;
    assign bus.port_we    = bus.ioctl_download | (state_q != S_IDLE) | ~empty;
    assign bus.rom_loaded = rom_loaded_q;
    assign bus.core_reset = core_reset_q;
endmodule

// File: tb/tb_m62_rom_loader.sv
// tb_m62_rom_loader: directed and random download streams checked against a queue-based write model.
module tb_m62_rom_loader;
    localparam logic [15:0] STRETCH = 16'd40;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    m62_rom_loader_if bus();
    m62_rom_loader #(.RST_STRETCH(STRETCH)) dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));

    always #5 clk_sys = ~clk_sys;

    int tests = 0, fails = 0, ack_dly = 0, n_issued = 0, c1 = 0, c2 = 0;
    bit saw_wait = 1'b0;
    logic [32:0] exp_q[$];
    logic p1_prev, p2_prev, a1_prev, a2_prev;
    logic [24:0] ea;
    logic [7:0] ed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // SDRAM stand-in: acknowledges each request toggle after ack_dly extra cycles.
    always @(posedge clk_sys) begin
        if (!reset_n) begin
            bus.port1_ack <= 1'b0;
            bus.port2_ack <= 1'b0;
            c1 <= 0;
            c2 <= 0;
        end else begin
            if (bus.port1_req != bus.port1_ack) begin
                if (c1 >= ack_dly) begin bus.port1_ack <= bus.port1_req; c1 <= 0; end
                else c1 <= c1 + 1;
            end
            if (bus.port2_req != bus.port2_ack) begin
                if (c2 >= ack_dly) begin bus.port2_ack <= bus.port2_req; c2 <= 0; end
                else c2 <= c2 + 1;
            end
        end
    end

    // Every port1 toggle must carry the oldest accepted byte with its region side effects.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            p1_prev = 1'b0; p2_prev = 1'b0; a1_prev = 1'b0; a2_prev = 1'b0;
            exp_q.delete();
        end else begin
            if (bus.ioctl_wait) saw_wait = 1'b1;
            if (bus.port1_req != p1_prev) begin
                chk("p1_no_overlap", 32'(a1_prev == p1_prev), 1);
                if (exp_q.size() == 0) chk("p1_spurious", 1, 0);
                else begin
                    {ea, ed} = exp_q.pop_front();
                    n_issued++;
                    chk("p1_a", 32'(bus.port1_a), (32'(ea) >> 1) & 32'h7FFFFF);
                    chk("p1_ds", 32'(bus.port1_ds), ea[0] ? 2 : 1);
                    chk("p1_d", 32'(bus.port1_d), 32'(ed) * 257);
                    chk("p2_toggle", 32'(bus.port2_req != p2_prev), 32'(ea >= 25'h30000));
                    if (ea >= 25'h30000) begin
                        chk("p2_no_overlap", 32'(a2_prev == p2_prev), 1);
                        chk("p2_a", 32'(bus.port2_a), ((32'(ea) - 32'h30000) >> 1) & 32'h7FFFFF);
                        chk("p2_ds", 32'(bus.port2_ds), ea[0] ? 2 : 1);
                        chk("p2_d", 32'(bus.port2_d), 32'(ed) * 257);
                    end
                    chk("snd_wr", 32'(bus.snd_wr), 32'(ea >= 25'h20000 && ea < 25'h30000));
                    if (ea >= 25'h20000 && ea < 25'h30000) begin
                        chk("snd_addr", 32'(bus.snd_addr), 32'(ea) & 32'hFFFF);
                        chk("snd_data", 32'(bus.snd_data), 32'(ed));
                    end
                    chk("dl_wr", 32'(bus.dl_wr), 32'(ea >= 25'hA0000));
                    if (ea >= 25'hA0000) begin
                        chk("dl_addr", 32'(bus.dl_addr), (32'(ea) - 32'hA0000) & 32'hFFFF);
                        chk("dl_data", 32'(bus.dl_data), 32'(ed));
                    end
                end
            end else if (bus.port2_req != p2_prev || bus.snd_wr || bus.dl_wr) begin
                chk("stray_strobe", {29'd0, bus.port2_req != p2_prev, bus.snd_wr, bus.dl_wr}, 0);
            end
            p1_prev = bus.port1_req; p2_prev = bus.port2_req;
            a1_prev = bus.port1_ack; a2_prev = bus.port2_ack;
        end
    end

    // Called at a negedge; drives one byte that is sampled by the following posedge.
    task automatic push(input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (bus.ioctl_wait && n < 300) begin @(negedge clk_sys); n++; end
        if (n >= 300) chk("wait_timeout", 1, 0);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = a; bus.ioctl_dout = d;
        exp_q.push_back({a, d});
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.port1_ack != bus.port1_req || bus.port2_ack != bus.port2_req) && n < 2000) begin
            @(negedge clk_sys); n++;
        end
        if (n >= 2000) chk("idle_timeout", 1, 0);
        repeat (2) @(negedge clk_sys);
    endtask

    function automatic logic [24:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 25'($urandom_range(0, 32'h1FFFF));
            1: return 25'($urandom_range(32'h20000, 32'h2FFFF));
            2: return 25'($urandom_range(32'h30000, 32'h9FFFF));
            default: return 25'($urandom_range(32'hA0000, 32'h1FFFFFF));
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [24:0] bnd[6];
        bus.ioctl_download = 0; bus.ioctl_index = 0; bus.ioctl_wr = 0;
        bus.ioctl_addr = 0; bus.ioctl_dout = 0; bus.user_reset = 0;
        repeat (3) @(negedge clk_sys);
        chk("rst_wait", 32'(bus.ioctl_wait), 0);
        chk("rst_p1_req", 32'(bus.port1_req), 0);
        chk("rst_p2_req", 32'(bus.port2_req), 0);
        chk("rst_snd_wr", 32'(bus.snd_wr), 0);
        chk("rst_dl_wr", 32'(bus.dl_wr), 0);
        chk("rst_rom_loaded", 32'(bus.rom_loaded), 0);
        chk("rst_core_reset", 32'(bus.core_reset), 1);
        chk("rst_p1_d", 32'(bus.port1_d), 0);
        chk("rst_p1_a", 32'(bus.port1_a), 0);
        chk("rst_dl_addr", 32'(bus.dl_addr), 0);
        chk("rst_port_we", 32'(bus.port_we), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Non-ROM index: bytes and the download end are ignored.
        bus.ioctl_index = 8'd5; bus.ioctl_download = 1'b1;
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h100; bus.ioctl_dout = 8'h33;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        repeat (5) @(negedge clk_sys);
        bus.ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk("idx_rom_loaded", 32'(bus.rom_loaded), 0);
        chk("idx_p1_req", 32'(bus.port1_req), 0);
        bus.ioctl_index = 8'd0; bus.ioctl_download = 1'b1;
        @(negedge clk_sys);

        // Single byte: request toggles two cycles after the push and waits for ack.
        ack_dly = 3;
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h1; bus.ioctl_dout = 8'h5A;
        exp_q.push_back({25'h1, 8'h5A});
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        chk("lat_cycle0", 32'(bus.port1_req), 0);
        @(negedge clk_sys);
        chk("lat_cycle1", 32'(bus.port1_req), 0);
        @(negedge clk_sys);
        chk("lat_cycle2", 32'(bus.port1_req), 1);
        chk("single_p2_req", 32'(bus.port2_req), 0);
        repeat (2) @(negedge clk_sys);
        chk("single_ack_pending", 32'(bus.port1_ack), 0);
        wait_idle();

        // Region decode and window boundaries.
        ack_dly = 1;
        push(25'h20010, 8'hA1);
        push(25'h30003, 8'hB2);
        push(25'hA0005, 8'hC3);
        bnd = '{25'h1FFFF, 25'h20000, 25'h2FFFF, 25'h30000, 25'h9FFFF, 25'hA0000};
        for (int i = 0; i < 6; i++) push(bnd[i], 8'($urandom));
        wait_idle();

        // Random streams with random ack latency.
        for (int i = 0; i < 40; i++) begin
            ack_dly = $urandom_range(0, 5);
            push(rand_addr(), 8'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk_sys);
        end
        wait_idle();

        // Backpressure: slow acks must raise ioctl_wait and lose nothing.
        ack_dly = 50; saw_wait = 1'b0; n = n_issued;
        for (int i = 0; i < 8; i++) push(25'h200 + 25'(i), 8'($urandom));
        wait_idle();
        chk("bp_wait_seen", 32'(saw_wait), 1);
        chk("bp_all_issued", 32'(n_issued - n), 8);
        chk("bp_wait_clear", 32'(bus.ioctl_wait), 0);
        chk("pre_rom_loaded", 32'(bus.rom_loaded), 0);
        chk("pre_core_reset", 32'(bus.core_reset), 1);

        // End of load with bytes still queued.
        ack_dly = 10;
        push(25'h400, 8'h11);
        push(25'h30400, 8'h22);
        push(25'hA0400, 8'h33);
        bus.ioctl_download = 1'b0;
        n = 0;
        while (!bus.rom_loaded && n < 500) begin @(negedge clk_sys); n++; end
        if (n >= 500) chk("eol_timeout", 1, 0);
        chk("eol_drained", 32'(exp_q.size()), 0);
        chk("eol_acked", 32'(bus.port1_ack == bus.port1_req && bus.port2_ack == bus.port2_req), 1);
        n = 0;
        while (bus.core_reset && n < 200) begin @(negedge clk_sys); n++; end
        chk("core_reset_stretch", 32'(n), 32'(STRETCH));
        bus.user_reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("user_reset_core", 32'(bus.core_reset), 1);
        bus.user_reset = 1'b0;
        chk("rom_loaded_sticky", 32'(bus.rom_loaded), 1);

        // Reset while a request is outstanding.
        bus.ioctl_download = 1'b1;
        ack_dly = 20;
        push(25'h123, 8'h77);
        n = 0;
        while (bus.port1_req == bus.port1_ack && n < 20) begin @(negedge clk_sys); n++; end
        chk("mid_in_wait", 32'(bus.port1_req != bus.port1_ack), 1);
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk("mid_p1_req", 32'(bus.port1_req), 0);
        chk("mid_p2_req", 32'(bus.port2_req), 0);
        chk("mid_rom_loaded", 32'(bus.rom_loaded), 0);
        chk("mid_core_reset", 32'(bus.core_reset), 1);
        chk("mid_wait", 32'(bus.ioctl_wait), 0);
        chk("mid_p1_d", 32'(bus.port1_d), 0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        ack_dly = 2;
        push(25'h0, 8'hFF);
        push(25'h1, 8'h02);
        push(25'h2, 8'h10);
        wait_idle();
        chk("post_rst_rom_loaded", 32'(bus.rom_loaded), 0);
`ifdef LOADER_CHECKSUM_EN
        chk("rom_sum", 32'(bus.rom_sum), 32'h0111);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
